// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, syncs, blanks and colour.
// The 'in' view is consumed by a pipeline stage, the 'out' view is produced by it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_grid.sv
// Overlays a COLS x ROWS formation of scaled sprites from a shared ROM onto a VGA stream.
// Frame-level controls are shadowed at vblnk rise so a frame is never drawn half-updated.
module draw_sprite_grid #(
    parameter int          SPR_W      = 16,
    parameter int          SPR_H      = 8,
    parameter int          COLS       = 8,
    parameter int          ROWS       = 4,
    parameter int          GAP_X      = 8,
    parameter int          GAP_Y      = 8,
    parameter int          SCALE_LOG2 = 1,
    parameter int          FRAMES     = 2,
    parameter int          ROM_LAT    = 1,
    parameter logic [11:0] KEY_COLOR  = 12'h000,
    parameter int          ADDR_W     = $clog2(FRAMES*SPR_W*SPR_H),
    localparam int         FSEL_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            xpos,
    input  logic [11:0]            ypos,
    input  logic [COLS*ROWS-1:0]   alive,
    input  logic [FSEL_W-1:0]      frame_sel,
    input  logic                   enabled,
    input  logic [11:0]            rgb_pixel,
    output logic [ADDR_W-1:0]      pixel_addr,
    vga_if.in                      draw_in,
    vga_if.out                     draw_out
);

    localparam int CW     = SPR_W << SCALE_LOG2;
    localparam int CH     = SPR_H << SCALE_LOG2;
    localparam int PX     = CW + GAP_X;
    localparam int PY     = CH + GAP_Y;
    localparam int GRID_W = COLS * PX;
    localparam int GRID_H = ROWS * PY;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IDX_W  = (COLS*ROWS > 1) ? $clog2(COLS*ROWS) : 1;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        draw;
    } pix_t;

    logic [11:0]          x_act_r;
    logic [11:0]          y_act_r;
    logic [COLS*ROWS-1:0] alive_act_r;
    logic [FSEL_W-1:0]    frame_act_r;
    logic                 en_act_r;
    logic                 vblnk_prev_r;
    logic                 vblnk_rise_s;
    logic [FSEL_W-1:0]    frame_clamp_s;

    logic signed [12:0]   dx_s;
    logic signed [12:0]   dy_s;
    int                   dx_i;
    int                   dy_i;
    int                   hoff_i;
    int                   voff_i;
    logic [COL_W-1:0]     col_s;
    logic [ROW_W-1:0]     row_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 in_grid_s;
    logic                 in_sprite_s;
    logic [ADDR_W-1:0]    addr_s;
    pix_t                 stage1_s;
    pix_t                 tail_s;
    pix_t                 pipe_r [ROM_LAT+1];
    logic [11:0]          out_rgb_s;

    assign vblnk_rise_s = draw_in.vblnk & ~vblnk_prev_r;

    // An out-of-range frame request shows the last stored frame instead
    generate
        if ((1 << FSEL_W) > FRAMES) begin : g_clamp
            always_comb begin
                if (frame_sel > FSEL_W'(FRAMES-1)) begin
                    frame_clamp_s = FSEL_W'(FRAMES-1);
                end else begin
                    frame_clamp_s = frame_sel;
                end
            end
        end else begin : g_no_clamp
            assign frame_clamp_s = frame_sel;
        end
    endgenerate

    // Shadow the frame-level controls on the rising edge of vblnk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev_r <= 1'b0;
            x_act_r      <= 12'd0;
            y_act_r      <= 12'd0;
            alive_act_r  <= '0;
            frame_act_r  <= '0;
            en_act_r     <= 1'b0;
        end else begin
            vblnk_prev_r <= draw_in.vblnk;
            if (vblnk_rise_s) begin
                x_act_r     <= xpos;
                y_act_r     <= ypos;
                alive_act_r <= alive;
                frame_act_r <= frame_clamp_s;
                en_act_r    <= enabled;
            end
        end
    end

    // Locate the pixel in the formation using constant range compares per cell
    always_comb begin
        dx_s   = $signed({2'b00, draw_in.hcount}) - $signed({1'b0, x_act_r});
        dy_s   = $signed({2'b00, draw_in.vcount}) - $signed({1'b0, y_act_r});
        dx_i   = int'(dx_s);
        dy_i   = int'(dy_s);
        col_s  = '0;
        row_s  = '0;
        hoff_i = 32'sd0;
        voff_i = 32'sd0;
        for (int c = 0; c < COLS; c++) begin
            col_s  = (dx_i >= c*PX && dx_i < (c+1)*PX) ? COL_W'(c)   : col_s;
            hoff_i = (dx_i >= c*PX && dx_i < (c+1)*PX) ? dx_i - c*PX : hoff_i;
        end
        for (int r = 0; r < ROWS; r++) begin
            row_s  = (dy_i >= r*PY && dy_i < (r+1)*PY) ? ROW_W'(r)   : row_s;
            voff_i = (dy_i >= r*PY && dy_i < (r+1)*PY) ? dy_i - r*PY : voff_i;
        end
        in_grid_s   = (dx_i >= 32'sd0) && (dx_i < GRID_W) && (dy_i >= 32'sd0) && (dy_i < GRID_H);
        in_sprite_s = in_grid_s && (hoff_i < CW) && (voff_i < CH);
        idx_s       = IDX_W'(int'(row_s) * COLS + int'(col_s));
        addr_s      = ADDR_W'(frame_act_r) * ADDR_W'(SPR_W*SPR_H)
                    + ADDR_W'(voff_i >>> SCALE_LOG2) * ADDR_W'(SPR_W)
                    + ADDR_W'(hoff_i >>> SCALE_LOG2);
    end

    // Assemble the stage-1 record: timing, upstream colour and the draw decision
    always_comb begin
        stage1_s.hcount = draw_in.hcount;
        stage1_s.vcount = draw_in.vcount;
        stage1_s.hsync  = draw_in.hsync;
        stage1_s.vsync  = draw_in.vsync;
        stage1_s.hblnk  = draw_in.hblnk;
        stage1_s.vblnk  = draw_in.vblnk;
        stage1_s.rgb    = draw_in.rgb;
        stage1_s.draw   = in_sprite_s && alive_act_r[idx_s] && en_act_r
                        && !draw_in.hblnk && !draw_in.vblnk;
    end

    // ROM address plus the delay line that matches the ROM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pixel_addr <= in_sprite_s ? addr_s : '0;
            pipe_r[0]  <= stage1_s;
            for (int i = 1; i <= ROM_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tail_s = pipe_r[ROM_LAT];

    // Key colour in the ROM lets the upstream picture show through the sprite
    always_comb begin
        if (tail_s.draw && (rgb_pixel != KEY_COLOR)) begin
            out_rgb_s = rgb_pixel;
        end else begin
            out_rgb_s = tail_s.rgb;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw_out.hcount <= 11'd0;
            draw_out.vcount <= 11'd0;
            draw_out.hsync  <= 1'b0;
            draw_out.vsync  <= 1'b0;
            draw_out.hblnk  <= 1'b0;
            draw_out.vblnk  <= 1'b0;
            draw_out.rgb    <= 12'd0;
        end else begin
            draw_out.hcount <= tail_s.hcount;
            draw_out.vcount <= tail_s.vcount;
            draw_out.hsync  <= tail_s.hsync;
            draw_out.vsync  <= tail_s.vsync;
            draw_out.hblnk  <= tail_s.hblnk;
            draw_out.vblnk  <= tail_s.vblnk;
            draw_out.rgb    <= out_rgb_s;
        end
    end

endmodule
